mem_interface: RTL and testbench

MEM_INTERFACE -- requirements
Module: mem_interface

---
 rtl/proc_pkg.sv | 15 +
 rtl/mem_timeout_counter.sv | 22 ++
 rtl/mem_interface.sv | 141 ++++++++++++++
 tb/tb_mem_interface.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: memory-interface FSM state encoding and bus/timeout defaults.
package proc_pkg;

    localparam int DATA_W_DEFAULT  = 16;
    localparam int ADDR_W_DEFAULT  = 16;
    localparam int TIMEOUT_DEFAULT = 255;
    localparam int TIMER_W         = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } memState_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Wait-cycle counter for the memory request phase; cleared when a request is accepted.
module mem_timeout_counter #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_interface.sv
// Multicycle-processor memory interface: registers one request, handshakes with memory and steers
// read data into IR or MDR. Defining MEM_TIMEOUT_EN adds an ack timeout with a sticky mem_err.
module mem_interface
    import proc_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IorD,
    input  logic              IRWrite,
    input  logic [ADDR_W-1:0] PC,
    input  logic [ADDR_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] inst,
    output logic [DATA_W-1:0] MDR,
    output logic              Stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_err
);

    memState_t         state;
    memState_t         nextState;
    logic              destIr;
    logic              request;
    logic              capture;
    logic              inReq;
    logic              timeoutHit;
    logic              loadEn;
    logic [DATA_W-1:0] loadData;

    if (TIMEOUT < 1 || TIMEOUT > (1 << TIMER_W) - 1) begin : gBadTimeout
        $error("mem_interface: TIMEOUT must be 1..%0d", (1 << TIMER_W) - 1);
    end

    assign request = MemRead | MemWrite;
    assign capture = (state == IDLE) && request;
    assign inReq   = (state == REQ);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        Stall     = 1'b0;
        mem_req   = 1'b0;
        case (state)
            IDLE: begin
                Stall = request;
                if (request) begin
                    nextState = REQ;
                end
            end
            REQ: begin
                Stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ack || timeoutHit) begin
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // A simultaneous read and write is treated as a write; the read is dropped.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            destIr    <= 1'b0;
        end else if (capture) begin
            mem_addr  <= IorD ? ALUOut : PC;
            mem_wdata <= B;
            mem_we    <= MemWrite;
            destIr    <= IRWrite;
        end
    end

    assign loadEn   = inReq && !mem_we && (mem_ack || timeoutHit);
    assign loadData = mem_ack ? mem_rdata : '0;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            inst <= '0;
            MDR  <= '0;
        end else if (loadEn) begin
            if (destIr) begin
                inst <= loadData;
            end else begin
                MDR <= loadData;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] waitCount;

    mem_timeout_counter #(
        .CNT_W(TIMER_W)
    ) uTimeoutCounter (
        .CLK   (CLK),
        .Reset (Reset),
        .clear (capture),
        .enable(inReq),
        .count (waitCount)
    );

    // The final permitted REQ cycle is the one whose count equals TIMEOUT-1; an ack there still wins.
    assign timeoutHit = inReq && (waitCount == TIMEOUT_LAST);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            mem_err <= 1'b0;
        end else if (timeoutHit && !mem_ack) begin
            mem_err <= 1'b1;
        end
    end
`else
    assign timeoutHit = 1'b0;
    assign mem_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_interface.sv
// Bench for mem_interface: table vectors, random transactions against a transaction-level model,
// and hand sequences for stray ack, back-to-back, reset abort and (with MEM_TIMEOUT_EN) timeout.
module tb_mem_interface;

    localparam int DW         = 16;
    localparam int AW         = 16;
    localparam int TB_TIMEOUT = 4;

    logic          CLK;
    logic          Reset;
    logic          MemRead;
    logic          MemWrite;
    logic          IorD;
    logic          IRWrite;
    logic [AW-1:0] PC;
    logic [AW-1:0] ALUOut;
    logic [DW-1:0] B;
    logic [DW-1:0] inst;
    logic [DW-1:0] MDR;
    logic          Stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          mem_err;

    typedef struct {
        logic          memRead;
        logic          memWrite;
        logic          iorD;
        logic          irWrite;
        logic [AW-1:0] pc;
        logic [AW-1:0] aluOut;
        logic [DW-1:0] b;
        logic [DW-1:0] rdata;
        int            ackDelay;
        logic [DW-1:0] expInst;
        logic [DW-1:0] expMdr;
        logic [AW-1:0] expAddr;
        logic [DW-1:0] expWdata;
        logic          expWe;
        int            expStall;
    } vector_t;

    vector_t       vecs[5];
    int            vectorCount;
    int            miscompares;
    int            obsStall;
    int            obsReq;
    logic [AW-1:0] obsAddr;
    logic [DW-1:0] obsWdata;
    logic          obsWe;
    logic [DW-1:0] modelInst;
    logic [DW-1:0] modelMdr;
    logic          modelErr;

    mem_interface #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .IorD     (IorD),
        .IRWrite  (IRWrite),
        .PC       (PC),
        .ALUOut   (ALUOut),
        .B        (B),
        .inst     (inst),
        .MDR      (MDR),
        .Stall    (Stall),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .mem_err  (mem_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic sampleCycle();
        @(negedge CLK);
        if (Stall) obsStall++;
        if (mem_req) obsReq++;
    endtask

    // Runs one transaction from IDLE back to IDLE; ack arrives after ackDelay wait cycles in REQ.
    task automatic applyStimulus(input logic rd, input logic wr, input logic selAlu, input logic toIr,
                                 input logic [AW-1:0] pc, input logic [AW-1:0] alu,
                                 input logic [DW-1:0] b, input logic [DW-1:0] rdata,
                                 input int ackDelay, input bit holdAfter);
        MemRead  = rd;
        MemWrite = wr;
        IorD     = selAlu;
        IRWrite  = toIr;
        PC       = pc;
        ALUOut   = alu;
        B        = b;
        mem_ack  = 1'b0;
        obsStall = 0;
        obsReq   = 0;
        sampleCycle();
        @(posedge CLK); #1;
        obsAddr  = mem_addr;
        obsWdata = mem_wdata;
        obsWe    = mem_we;
        PC       = AW'($urandom);
        ALUOut   = AW'($urandom);
        B        = DW'($urandom);
        IorD     = ~selAlu;
        IRWrite  = ~toIr;
        for (int i = 0; i <= ackDelay; i++) begin
            mem_ack   = (i == ackDelay);
            mem_rdata = (i == ackDelay) ? rdata : DW'($urandom);
            sampleCycle();
            @(posedge CLK); #1;
        end
        mem_ack   = 1'b0;
        mem_rdata = DW'($urandom);
        if (!holdAfter) begin
            MemRead  = 1'b0;
            MemWrite = 1'b0;
        end
        sampleCycle();
        @(posedge CLK); #1;
    endtask

    task automatic checkTransaction(input string tag, input logic [AW-1:0] expAddr,
                                    input logic [DW-1:0] expWdata, input logic expWe,
                                    input int expStall, input int expReq);
        checkOutput({tag, "_addr"}, 32'(obsAddr), 32'(expAddr));
        checkOutput({tag, "_wdata"}, 32'(obsWdata), 32'(expWdata));
        checkOutput({tag, "_we"}, 32'(obsWe), 32'(expWe));
        checkOutput({tag, "_stall_cycles"}, obsStall, expStall);
        checkOutput({tag, "_req_cycles"}, obsReq, expReq);
        checkOutput({tag, "_inst"}, 32'(inst), 32'(modelInst));
        checkOutput({tag, "_mdr"}, 32'(MDR), 32'(modelMdr));
        checkOutput({tag, "_err"}, 32'(mem_err), 32'(modelErr));
    endtask

    initial begin
        logic          rd;
        logic          wr;
        logic          selAlu;
        logic          toIr;
        logic [AW-1:0] pc;
        logic [AW-1:0] alu;
        logic [DW-1:0] b;
        logic [DW-1:0] rdata;
        int            op;
        int            d;
        int            reqCycles;

        vectorCount = 0;
        miscompares = 0;
        modelInst   = '0;
        modelMdr    = '0;
        modelErr    = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0040, 16'h9999, 16'h1111, 16'h5A3B, 0,
                    16'h5A3B, 16'h0000, 16'h0040, 16'h1111, 1'b0, 2};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0042, 16'h0100, 16'h2222, 16'h1234, 3,
                    16'h5A3B, 16'h1234, 16'h0100, 16'h2222, 1'b0, 5};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0044, 16'h0200, 16'hBEEF, 16'hDEAD, 1,
                    16'h5A3B, 16'h1234, 16'h0200, 16'hBEEF, 1'b1, 3};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0044, 16'h0300, 16'h0000, 16'hC0DE, 2,
                    16'hC0DE, 16'h1234, 16'h0044, 16'h0000, 1'b0, 4};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0046, 16'h0310, 16'h7777, 16'hFFFF, 0,
                    16'hC0DE, 16'h1234, 16'h0046, 16'h7777, 1'b1, 2};

        Reset     = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        PC        = '0;
        ALUOut    = '0;
        B         = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        #3;
        checkOutput("reset_inst", 32'(inst), 32'h0);
        checkOutput("reset_mdr", 32'(MDR), 32'h0);
        checkOutput("reset_addr", 32'(mem_addr), 32'h0);
        checkOutput("reset_wdata", 32'(mem_wdata), 32'h0);
        checkOutput("reset_req", 32'(mem_req), 32'h0);
        checkOutput("reset_we", 32'(mem_we), 32'h0);
        checkOutput("reset_err", 32'(mem_err), 32'h0);
        checkOutput("reset_stall", 32'(Stall), 32'h0);
        @(negedge CLK);
        Reset = 1'b1;
        @(posedge CLK); #1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].memRead, vecs[i].memWrite, vecs[i].iorD, vecs[i].irWrite,
                          vecs[i].pc, vecs[i].aluOut, vecs[i].b, vecs[i].rdata,
                          vecs[i].ackDelay, 1'b0);
            modelInst = vecs[i].expInst;
            modelMdr  = vecs[i].expMdr;
            checkTransaction($sformatf("vec%0d", i), vecs[i].expAddr, vecs[i].expWdata,
                             vecs[i].expWe, vecs[i].expStall, vecs[i].ackDelay + 1);
        end

        for (int n = 0; n < 20; n++) begin
            op     = int'($urandom_range(0, 2));
            rd     = (op != 1);
            wr     = (op != 0);
            selAlu = 1'($urandom);
            toIr   = 1'($urandom);
            pc     = AW'($urandom);
            alu    = AW'($urandom);
            b      = DW'($urandom);
            rdata  = DW'($urandom);
            d      = int'($urandom_range(0, 2));
            applyStimulus(rd, wr, selAlu, toIr, pc, alu, b, rdata, d, 1'b0);
            if (!wr) begin
                if (toIr) modelInst = rdata;
                else      modelMdr  = rdata;
            end
            checkTransaction($sformatf("rand%0d", n), selAlu ? alu : pc, b, wr, d + 2, d + 1);
        end

        mem_ack   = 1'b1;
        mem_rdata = 16'hAAAA;
        @(negedge CLK);
        checkOutput("stray_req", 32'(mem_req), 32'h0);
        checkOutput("stray_stall", 32'(Stall), 32'h0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        mem_ack = 1'b0;
        checkOutput("stray_inst", 32'(inst), 32'(modelInst));
        checkOutput("stray_mdr", 32'(MDR), 32'(modelMdr));

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0070, 16'h0400, 16'h0000, 16'h3C3C, 1, 1'b1);
        modelMdr = 16'h3C3C;
        checkTransaction("b2b_first", 16'h0400, 16'h0000, 1'b0, 3, 2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h0072, 16'h0500, 16'h0000, 16'h4D4D, 0, 1'b0);
        modelInst = 16'h4D4D;
        checkTransaction("b2b_second", 16'h0072, 16'h0000, 1'b0, 2, 1);

`ifdef MEM_TIMEOUT_EN
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        IRWrite  = 1'b1;
        IorD     = 1'b0;
        PC       = 16'h0060;
        mem_ack  = 1'b0;
        @(posedge CLK); #1;
        MemRead   = 1'b0;
        reqCycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (!mem_req) break;
            reqCycles++;
        end
        checkOutput("timeout_req_cycles", reqCycles, TB_TIMEOUT);
        checkOutput("timeout_err", 32'(mem_err), 32'h1);
        checkOutput("timeout_inst", 32'(inst), 32'h0);
        @(posedge CLK); #1;
        modelInst = '0;
        modelErr  = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0080, 16'h0600, 16'h0000, 16'h6E6E, 0, 1'b0);
        modelMdr = 16'h6E6E;
        checkTransaction("after_timeout", 16'h0600, 16'h0000, 1'b0, 2, 1);
`endif

        MemRead  = 1'b1;
        MemWrite = 1'b0;
        IRWrite  = 1'b1;
        IorD     = 1'b0;
        PC       = 16'h0050;
        mem_ack  = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        checkOutput("abort_req_before", 32'(mem_req), 32'h1);
        MemRead = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        checkOutput("abort_req", 32'(mem_req), 32'h0);
        checkOutput("abort_stall", 32'(Stall), 32'h0);
        checkOutput("abort_inst", 32'(inst), 32'h0);
        checkOutput("abort_mdr", 32'(MDR), 32'h0);
        checkOutput("abort_addr", 32'(mem_addr), 32'h0);
        checkOutput("abort_err", 32'(mem_err), 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 16'h7E57;
        @(posedge CLK); #1;
        mem_ack = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("post_abort_inst", 32'(inst), 32'h0);
        checkOutput("post_abort_mdr", 32'(MDR), 32'h0);
        checkOutput("post_abort_req", 32'(mem_req), 32'h0);
        modelInst = '0;
        modelMdr  = '0;
        modelErr  = 1'b0;

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h0090, 16'h0700, 16'hCAFE, 16'h5555, 1, 1'b0);
        checkTransaction("post_abort_store", 16'h0700, 16'hCAFE, 1'b1, 3, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
        $finish;
    end

endmodule
